// File: rtl/pmem_line_server_pkg.sv
// Shared types and constants for the cache-line pmem responder.
package pmem_line_server_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    RESP
  } pmem_srv_state_t;

  localparam int LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/pmem_line_server_line_beat_buffer.sv
// Line register with beat-indexed fill (read bursts) and beat-indexed drain mux (write bursts).
module line_beat_buffer #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              fill,
  input  logic [IDX_W-1:0]  beat,
  input  logic [BEAT_W-1:0] fill_beat,
  output logic [LINE_W-1:0] fill_line,
  output logic [BEAT_W-1:0] beat_out
);

  logic [LINE_W-1:0] line;

  // fill_line is the line as it will look once the current beat lands
  always_comb begin
    fill_line = line;
    fill_line[int'(beat)*BEAT_W +: BEAT_W] = fill_beat;
  end

  assign beat_out = line[int'(beat)*BEAT_W +: BEAT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
    end else if (load) begin
      line <= load_line;
    end else if (fill) begin
      line <= fill_line;
    end
  end

endmodule

// File: rtl/pmem_line_server.sv
// Serves 256-bit pmem line requests by bursting narrow beats to/from backing memory.
module pmem_line_server
  import pmem_line_server_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic              pmem_resp,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [ADDR_W-1:0] bmem_address,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_resp
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

  pmem_srv_state_t state, next_state;
  logic [IDX_W-1:0]  beat;
  logic              accept;
  logic              load;
  logic              fill;
  logic              beat_done;
  logic              last;
  logic [LINE_W-1:0] fill_line;
  logic              unused_offset;

  // Offset bits are dropped by alignment; keep them visibly consumed.
  assign unused_offset = ^pmem_address[LINE_OFFSET_BITS-1:0];

  assign last      = (beat == LAST_BEAT);
  assign pmem_resp = (state == RESP);

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    load       = 1'b0;
    fill       = 1'b0;
    beat_done  = 1'b0;
    unique case (state)
      IDLE: begin
        // Write has priority; a simultaneous read stays pending until after RESP.
        if (pmem_write) begin
          next_state = WR_BURST;
          accept     = 1'b1;
          load       = 1'b1;
        end else if (pmem_read) begin
          next_state = RD_BURST;
          accept     = 1'b1;
        end
      end
      RD_BURST: begin
        if (bmem_resp) begin
          fill      = 1'b1;
          beat_done = 1'b1;
          if (last) next_state = RESP;
        end
      end
      WR_BURST: begin
        if (bmem_resp) begin
          beat_done = 1'b1;
          if (last) next_state = RESP;
        end
      end
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      beat         <= '0;
      bmem_read    <= 1'b0;
      bmem_write   <= 1'b0;
      bmem_address <= '0;
      pmem_rdata   <= '0;
    end else begin
      state      <= next_state;
      bmem_read  <= (next_state == RD_BURST);
      bmem_write <= (next_state == WR_BURST);
      if (accept) begin
        beat         <= '0;
        bmem_address <= {pmem_address[ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
      end else if (beat_done) begin
        beat <= last ? '0 : beat + 1'b1;
      end
      // Publish the full line including the beat arriving this cycle.
      if (fill && last) pmem_rdata <= fill_line;
    end
  end

  line_beat_buffer #(
    .LINE_W(LINE_W),
    .BEAT_W(BEAT_W),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_line(pmem_wdata),
    .fill     (fill),
    .beat     (beat),
    .fill_beat(bmem_rdata),
    .fill_line(fill_line),
    .beat_out (bmem_wdata)
  );

endmodule

// File: tb/tb_pmem_line_server.sv
// Directed bench for pmem_line_server with a small backing-memory responder.
module tb_pmem_line_server;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         bmem_read, bmem_write;
  logic [31:0]  bmem_address;
  logic [63:0]  bmem_wdata;
  logic [63:0]  bmem_rdata;
  logic         bmem_resp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pmem_line_server dut (
    .clk         (clk),
    .rst         (rst),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_resp   (pmem_resp),
    .pmem_rdata  (pmem_rdata),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_address(bmem_address),
    .bmem_wdata  (bmem_wdata),
    .bmem_rdata  (bmem_rdata),
    .bmem_resp   (bmem_resp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Backing-memory model: answers each beat after 'gap' idle cycles until pmem_resp appears.
  task automatic serve(input int gap,
                       input logic [63:0] b0, input logic [63:0] b1,
                       input logic [63:0] b2, input logic [63:0] b3,
                       input logic [255:0] wl,
                       output int cyc, output int rdn, output int wrn, output int holdbad,
                       output logic [31:0] adr, output logic [255:0] wcap, output logic done);
    logic [63:0] rb [4];
    int gc, idx;
    logic adr_set;
    rb[0] = b0; rb[1] = b1; rb[2] = b2; rb[3] = b3;
    cyc = 1; rdn = 0; wrn = 0; holdbad = 0; adr = '0; wcap = '0; done = 1'b0;
    gc = 0; idx = 0; adr_set = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (pmem_resp) begin
        done = 1'b1;
        bmem_resp = 1'b0;
      end else begin
        if (bmem_write && idx < 4 && bmem_wdata !== wl[idx*64 +: 64]) holdbad++;
        if (bmem_read || bmem_write) begin
          if (!adr_set) begin
            adr = bmem_address;
            adr_set = 1'b1;
          end
          if (gc == gap) begin
            bmem_resp  = 1'b1;
            bmem_rdata = (idx < 4) ? rb[idx] : 64'h0;
            if (bmem_write && idx < 4) wcap[idx*64 +: 64] = bmem_wdata;
            if (bmem_read) rdn++;
            else wrn++;
            idx++;
            gc = 0;
          end else begin
            bmem_resp = 1'b0;
            gc++;
          end
        end else begin
          bmem_resp = 1'b0;
        end
        step();
        cyc++;
      end
    end
  endtask

  localparam logic [63:0] B11 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B22 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B33 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B44 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] BA  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BB  = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] BC  = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] BD  = 64'hDDDD_DDDD_DDDD_DDDD;

  initial begin
    int cyc, rdn, wrn, hb;
    logic [31:0] adr;
    logic [255:0] wcap, r1, wline, w2, r2, r3, r4;
    logic done;

    r1    = {B44, B33, B22, B11};
    wline = {BD, BC, BB, BA};
    w2    = {64'h0808_0808_0808_0808, 64'h0707_0707_0707_0707,
             64'h0606_0606_0606_0606, 64'h0505_0505_0505_0505};
    r2    = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
             64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
    r3    = {64'hF4F4_F4F4_F4F4_F4F4, 64'hF3F3_F3F3_F3F3_F3F3,
             64'hF2F2_F2F2_F2F2_F2F2, 64'hF1F1_F1F1_F1F1_F1F1};
    r4    = {64'h0BAD_0000_0000_0004, 64'h0BAD_0000_0000_0003,
             64'h0BAD_0000_0000_0002, 64'h0BAD_0000_0000_0001};

    rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0;
    pmem_wdata = '0; bmem_rdata = '0; bmem_resp = 1'b0;
    step(); step();
    check("rst_resp",  {255'b0, pmem_resp},  256'd0);
    check("rst_rdata", pmem_rdata,           256'd0);
    check("rst_bread", {255'b0, bmem_read},  256'd0);
    check("rst_bwrite",{255'b0, bmem_write}, 256'd0);
    check("rst_baddr", {224'b0, bmem_address}, 256'd0);
    check("rst_bwdata",{192'b0, bmem_wdata}, 256'd0);
    rst = 1'b0;
    step();

    // Read with back-to-back beats
    pmem_read = 1'b1; pmem_address = 32'h0000_1234;
    serve(0, B11, B22, B33, B44, '0, cyc, rdn, wrn, hb, adr, wcap, done);
    check("rd1_done",  {255'b0, done}, 256'd1);
    check("rd1_cycle", 256'(cyc), 256'd6);
    check("rd1_addr",  {224'b0, adr}, 256'h1220);
    check("rd1_beats", 256'(rdn), 256'd4);
    check("rd1_rdata", pmem_rdata, r1);
    check("rd1_bread_off", {255'b0, bmem_read}, 256'd0);
    step();
    pmem_read = 1'b0;
    check("rd1_resp_once", {255'b0, pmem_resp}, 256'd0);
    step();

    // Write with 2-cycle gaps between acceptances
    pmem_write = 1'b1; pmem_address = 32'h0000_0040; pmem_wdata = wline;
    serve(2, '0, '0, '0, '0, wline, cyc, rdn, wrn, hb, adr, wcap, done);
    check("wr_done",   {255'b0, done}, 256'd1);
    check("wr_addr",   {224'b0, adr}, 256'h40);
    check("wr_beats",  256'(wrn), 256'd4);
    check("wr_rdbeats",256'(rdn), 256'd0);
    check("wr_seq",    wcap, wline);
    check("wr_hold",   256'(hb), 256'd0);
    check("wr_rdata_kept", pmem_rdata, r1);
    step();
    pmem_write = 1'b0;
    check("wr_resp_once", {255'b0, pmem_resp}, 256'd0);
    step();

    // Read and write together: write first, read served afterwards
    pmem_read = 1'b1; pmem_write = 1'b1; pmem_address = 32'h0000_0080; pmem_wdata = w2;
    serve(0, '0, '0, '0, '0, w2, cyc, rdn, wrn, hb, adr, wcap, done);
    check("both_wr_done",  {255'b0, done}, 256'd1);
    check("both_wr_beats", 256'(wrn), 256'd4);
    check("both_wr_nord",  256'(rdn), 256'd0);
    check("both_wr_seq",   wcap, w2);
    check("both_wr_addr",  {224'b0, adr}, 256'h80);
    step();
    pmem_write = 1'b0;
    serve(0, r2[63:0], r2[127:64], r2[191:128], r2[255:192], '0,
          cyc, rdn, wrn, hb, adr, wcap, done);
    check("both_rd_done",  {255'b0, done}, 256'd1);
    check("both_rd_beats", 256'(rdn), 256'd4);
    check("both_rd_nowr",  256'(wrn), 256'd0);
    check("both_rd_rdata", pmem_rdata, r2);
    step();
    pmem_read = 1'b0;
    step();

    // Reset after two read beats
    pmem_read = 1'b1; pmem_address = 32'h0000_0100;
    step();
    check("rst_mid_bread_on", {255'b0, bmem_read}, 256'd1);
    bmem_resp = 1'b1; bmem_rdata = 64'hDEAD_0000_0000_0001;
    step();
    bmem_rdata = 64'hDEAD_0000_0000_0002;
    step();
    bmem_resp = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_bread",  {255'b0, bmem_read}, 256'd0);
    check("rst_mid_resp",   {255'b0, pmem_resp}, 256'd0);
    check("rst_mid_rdata",  pmem_rdata, 256'd0);
    serve(0, r3[63:0], r3[127:64], r3[191:128], r3[255:192], '0,
          cyc, rdn, wrn, hb, adr, wcap, done);
    check("rst_new_done",  {255'b0, done}, 256'd1);
    check("rst_new_cycle", 256'(cyc), 256'd6);
    check("rst_new_beats", 256'(rdn), 256'd4);
    check("rst_new_rdata", pmem_rdata, r3);
    step();
    pmem_read = 1'b0;

    // Idle with stray bmem_resp: nothing starts, rdata holds
    bmem_resp = 1'b1; bmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); step(); step();
    check("stray_bread",  {255'b0, bmem_read}, 256'd0);
    check("stray_resp",   {255'b0, pmem_resp}, 256'd0);
    check("stray_rdata",  pmem_rdata, r3);
    bmem_resp = 1'b0;

    // Back-to-back reads
    pmem_read = 1'b1; pmem_address = 32'h0000_2000;
    serve(0, r4[63:0], r4[127:64], r4[191:128], r4[255:192], '0,
          cyc, rdn, wrn, hb, adr, wcap, done);
    check("b2b1_beats", 256'(rdn), 256'd4);
    check("b2b1_rdata", pmem_rdata, r4);
    step();
    pmem_read = 1'b0;
    step();
    pmem_read = 1'b1; pmem_address = 32'h0000_203F;
    serve(1, B11, B22, B33, B44, '0, cyc, rdn, wrn, hb, adr, wcap, done);
    check("b2b2_done",  {255'b0, done}, 256'd1);
    check("b2b2_beats", 256'(rdn), 256'd4);
    check("b2b2_addr",  {224'b0, adr}, 256'h2020);
    check("b2b2_rdata", pmem_rdata, r1);
    step();
    pmem_read = 1'b0;
    step(); step();
    check("b2b_no_dup", {255'b0, bmem_read}, 256'd0);
    check("b2b_no_resp", {255'b0, pmem_resp}, 256'd0);
    check("b2b_rdata_hold", pmem_rdata, r1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
